// File: rtl/vga_timing_pkg.sv
// Nominal 640x480@60 timing constants and shared types for the VGA sync decoder.
package vga_timing_pkg;

    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_BP        = 48;
    localparam int unsigned H_ACT       = 640;
    localparam int unsigned H_FP        = 16;
    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned H_START     = H_SYNC + H_BP;

    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BP        = 33;
    localparam int unsigned V_ACT       = 480;
    localparam int unsigned V_FP        = 10;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned V_START     = V_SYNC + V_BP;

    localparam int unsigned LOCK_FRAMES = 2;

    localparam int unsigned CNT_W       = 11;
    localparam int unsigned WID_W       = 8;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

endpackage

// File: rtl/sync_axis_meter.sv
// One timing axis: detects the sync falling edge, counts period and sync-low width,
// and flags a mismatch against the nominal values when the period closes.
module sync_axis_meter
    import vga_timing_pkg::*;
#(
    parameter int unsigned PERIOD = 800,
    parameter int unsigned WIDTH  = 96
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             en,
    input  logic             adv,
    input  logic             sync,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             fall,
    output logic             bad
);

    localparam logic [CNT_W:0]   PERIOD_C = (CNT_W + 1)'(PERIOD);
    localparam logic [WID_W-1:0] WIDTH_C  = WID_W'(WIDTH);

    logic             sync_q;
    logic [CNT_W-1:0] cnt;
    logic [WID_W-1:0] wid;
    logic [WID_W-1:0] wid_nxt;
    logic [CNT_W:0]   period;

    always_comb begin
        fall    = en & ~sync & sync_q;
        cnt_nxt = cnt;
        wid_nxt = wid;
        if (fall) begin
            cnt_nxt = '0;
            wid_nxt = WID_W'(1);
        end else if (adv) begin
            if (cnt != '1)
                cnt_nxt = cnt + 1'b1;
            if (!sync && wid != '1)
                wid_nxt = wid + 1'b1;
        end
        // A saturated counter can never equal the nominal period, so it reads as bad.
        period = {1'b0, cnt} + 1'b1;
        bad    = fall & ((period != PERIOD_C) | (wid != WIDTH_C));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync_q <= 1'b1;
            cnt    <= '0;
            wid    <= '0;
        end else begin
            if (en)
                sync_q <= sync;
            cnt <= cnt_nxt;
            wid <= wid_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates from HS/VS, checks line and
// frame timing, and locks after enough consecutive good frames.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned H_ACT       = vga_timing_pkg::H_ACT,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter int unsigned V_ACT       = vga_timing_pkg::V_ACT,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hs,
    input  logic       vs,
    input  logic [1:0] r,
    input  logic [1:0] g,
    input  logic [1:0] b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic [5:0] rgb_out,
    output logic       frame_start,
    output logic       locked,
    output logic       err_line,
    output logic       err_frame
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_SYNC + V_BP + V_ACT);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    state_t           state, state_nxt;
    logic [3:0]       good, good_nxt;
    logic             line_acc, line_acc_nxt;
    logic             line_bad, frame_bad;
    logic             hs_fall, vs_fall, h_bad, v_bad;
    logic [CNT_W-1:0] hcnt_nxt, vcnt_nxt;
    logic             act_nxt;

    sync_axis_meter #(.PERIOD(H_TOTAL), .WIDTH(H_SYNC)) u_hmeter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (pix_en),
        .adv      (pix_en),
        .sync     (hs),
        .cnt_nxt  (hcnt_nxt),
        .fall     (hs_fall),
        .bad      (h_bad)
    );

    sync_axis_meter #(.PERIOD(V_TOTAL), .WIDTH(V_SYNC)) u_vmeter (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (pix_en),
        .adv      (hs_fall),
        .sync     (vs),
        .cnt_nxt  (vcnt_nxt),
        .fall     (vs_fall),
        .bad      (v_bad)
    );

    always_comb begin
        state_nxt    = state;
        good_nxt     = good;
        // SEARCH ignores timing, so the line closed by the entry edge is never judged.
        line_bad     = h_bad & (state != SEARCH);
        frame_bad    = vs_fall & (state != SEARCH) & (v_bad | line_acc | line_bad);
        line_acc_nxt = vs_fall ? 1'b0 : (line_acc | line_bad);
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                end
            end
            MEASURE: begin
                if (line_bad && frame_bad) begin
                    state_nxt = SEARCH;
                end else if (frame_bad) begin
                    good_nxt = '0;
                end else if (vs_fall) begin
                    if (good + 4'd1 >= LOCK_N)
                        state_nxt = LOCKED;
                    else
                        good_nxt = good + 4'd1;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
        act_nxt = (state_nxt == LOCKED) &&
                  (hcnt_nxt >= H_LO) && (hcnt_nxt < H_HI) &&
                  (vcnt_nxt >= V_LO) && (vcnt_nxt < V_HI);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state    <= SEARCH;
            good     <= '0;
            line_acc <= 1'b0;
        end else begin
            state    <= state_nxt;
            good     <= good_nxt;
            line_acc <= line_acc_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            x           <= '1;
            y           <= '1;
            active      <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            frame_start <= vs_fall && (state_nxt == LOCKED);
            err_line    <= line_bad;
            err_frame   <= frame_bad;
            if (pix_en) begin
                active  <= act_nxt;
                x       <= act_nxt ? 10'(hcnt_nxt - H_LO) : '1;
                y       <= act_nxt ? 10'(vcnt_nxt - V_LO) : '1;
                rgb_out <= act_nxt ? {r, g, b} : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboarded bench for vga_sync_decoder using a shrunken timing set so frames are short.
module tb_vga_sync_decoder;

    localparam int T_HS = 4, T_HB = 3, T_HA = 8, T_HF = 2;
    localparam int T_VS = 2, T_VB = 2, T_VA = 4, T_VF = 2;
    localparam int H_TOT = T_HS + T_HB + T_HA + T_HF;
    localparam int V_TOT = T_VS + T_VB + T_VA + T_VF;
    localparam int H_ST  = T_HS + T_HB;
    localparam int V_ST  = T_VS + T_VB;
    localparam int S_SEARCH = 0, S_MEASURE = 1, S_LOCKED = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic [5:0] rgb;
        logic       fs;
        logic       el;
        logic       ef;
        logic       lk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, pix_en, hs, vs;
    logic [1:0] r, g, b;
    logic [9:0] x, y;
    logic       active, frame_start, locked, err_line, err_frame;
    logic [5:0] rgb_out;

    exp_t exp_q[$];
    exp_t e_cur;
    int   total = 0;
    int   bad   = 0;

    int   m_st, m_good;
    logic m_acc, hs_prev, vs_prev, last_line_bad;

    vga_sync_decoder #(
        .H_SYNC(T_HS), .H_BP(T_HB), .H_ACT(T_HA), .H_FP(T_HF),
        .V_SYNC(T_VS), .V_BP(T_VB), .V_ACT(T_VA), .V_FP(T_VF),
        .LOCK_FRAMES(2)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hs          (hs),
        .vs          (vs),
        .r           (r),
        .g           (g),
        .b           (b),
        .x           (x),
        .y           (y),
        .active      (active),
        .rgb_out     (rgb_out),
        .frame_start (frame_start),
        .locked      (locked),
        .err_line    (err_line),
        .err_frame   (err_frame)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the expected registered outputs after the next edge are queued.
    task automatic cyc(input logic rn, input logic pe, input logic h, input logic v,
                       input logic [5:0] c, input int k, input int j);
        logic hf, vf, lb, fb, act;
        int   nst;
        @(negedge clk);
        reset = rn; pix_en = pe; hs = h; vs = v;
        r = c[5:4]; g = c[3:2]; b = c[1:0];
        if (!rn) begin
            m_st = S_SEARCH; m_good = 0; m_acc = 1'b0;
            hs_prev = 1'b1; vs_prev = 1'b1;
            e_cur.x = 10'd1023; e_cur.y = 10'd1023; e_cur.active = 1'b0;
            e_cur.rgb = 6'd0; e_cur.fs = 1'b0; e_cur.el = 1'b0; e_cur.ef = 1'b0;
            e_cur.lk = 1'b0;
        end else if (pe) begin
            hf  = !h && hs_prev;
            vf  = !v && vs_prev;
            lb  = hf && (m_st != S_SEARCH) && last_line_bad;
            fb  = vf && (m_st != S_SEARCH) && (m_acc || lb);
            nst = m_st;
            if (m_st == S_SEARCH) begin
                if (vf) begin nst = S_MEASURE; m_good = 0; end
            end else if (lb && fb) begin
                nst = S_SEARCH;
            end else if (m_st == S_MEASURE) begin
                if (fb) m_good = 0;
                else if (vf) begin
                    if (m_good + 1 >= 2) nst = S_LOCKED;
                    else m_good++;
                end
            end else if (lb || fb) begin
                nst = S_SEARCH;
            end
            m_acc = vf ? 1'b0 : (m_acc || lb);
            act = (k >= H_ST) && (k < H_ST + T_HA) && (j >= V_ST) && (j < V_ST + T_VA)
                  && (nst == S_LOCKED);
            e_cur.x      = act ? 10'(k - H_ST) : 10'd1023;
            e_cur.y      = act ? 10'(j - V_ST) : 10'd1023;
            e_cur.active = act;
            e_cur.rgb    = act ? c : 6'd0;
            e_cur.fs     = vf && (nst == S_LOCKED);
            e_cur.el     = lb;
            e_cur.ef     = fb;
            e_cur.lk     = (nst == S_LOCKED);
            m_st = nst; hs_prev = h; vs_prev = v;
        end else begin
            e_cur.fs = 1'b0; e_cur.el = 1'b0; e_cur.ef = 1'b0;
        end
        exp_q.push_back(e_cur);
    endtask

    task automatic send_line(input int len, input int sw, input int j,
                             input int hold_at, input int rst_at);
        logic       vl, hv;
        logic [5:0] c;
        vl = (j < T_VS) ? 1'b0 : 1'b1;
        for (int k = 0; k < len; k++) begin
            c  = 6'((k * 5 + j * 11) % 64);
            hv = (k < sw) ? 1'b0 : 1'b1;
            cyc(1'b1, 1'b1, hv, vl, c, k, j);
            cyc(1'b1, 1'b0, hv, vl, c, k, j);
            if (k == hold_at)
                for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, hv, vl, ~c, k, j);
            if (k == rst_at)
                cyc(1'b0, 1'b1, hv, vl, c, k, j);
        end
        last_line_bad = (len != H_TOT) || (sw != T_HS);
    endtask

    task automatic send_frame(input int bad_j, input int bad_len, input int bad_sw,
                              input int hold_j, input int rst_j);
        for (int j = 0; j < V_TOT; j++)
            send_line((j == bad_j) ? bad_len : H_TOT, (j == bad_j) ? bad_sw : T_HS, j,
                      (j == hold_j) ? 10 : -1, (j == rst_j) ? 9 : -1);
    endtask

    always @(posedge clk) begin
        exp_t ex, ac;
        #1;
        if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            ac.x = x; ac.y = y; ac.active = active; ac.rgb = rgb_out;
            ac.fs = frame_start; ac.el = err_line; ac.ef = err_frame; ac.lk = locked;
            total++;
            if (ac !== ex) begin
                bad++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d act=%b rgb=%h fs=%b el=%b ef=%b lk=%b want x=%0d y=%0d act=%b rgb=%h fs=%b el=%b ef=%b lk=%b",
                         $time, ac.x, ac.y, ac.active, ac.rgb, ac.fs, ac.el, ac.ef, ac.lk,
                         ex.x, ex.y, ex.active, ex.rgb, ex.fs, ex.el, ex.ef, ex.lk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1;
        r = 2'd0; g = 2'd0; b = 2'd0;
        last_line_bad = 1'b0;
        e_cur = '0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 0, 0);
        repeat (4) send_frame(-1, 0, 0, -1, -1);
        send_frame(-1, 0, 0, 5, -1);
        send_frame(3, H_TOT + 1, T_HS, -1, -1);
        repeat (2) send_frame(-1, 0, 0, -1, -1);
        send_frame(-1, 0, 0, -1, 6);
        send_frame(2, H_TOT, T_HS - 1, -1, -1);
        repeat (2) send_frame(-1, 0, 0, -1, -1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 0, 0);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive side of the 640x480@60 VGA timing interface: consumes active-low HS/VS plus 2-bit R/G/B, sampled on a 25 MHz pixel enable in the CLOCK_50 domain.
- Recovers pixel coordinates, checks line/frame timing against nominal values and locks to the stream.
- Used as an on-chip monitor/capture front end: self-check of the display path, and as a source for a frame-capture writer.

Parameters:
- H_SYNC, 96, hsync low width in pixels
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch (H_TOTAL = 800)
- V_SYNC, 2, vsync low width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch (V_TOTAL = 525)
- LOCK_FRAMES, 2, consecutive good frames needed to lock

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-low
- pix_en  in  1  one-cycle pixel-sample strobe (every 2nd clock nominally)
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- r, g, b  in  2 each  pixel colour
- x  out  10  active column, 1023 when inactive
- y  out  10  active row, 1023 when inactive
- active  out  1  locked and inside the active window
- rgb_out  out  6  registered {r,g,b}, zero when not active
- frame_start  out  1  one-clock pulse
- locked  out  1  state == LOCKED
- err_line  out  1  one-clock pulse on line timing error
- err_frame  out  1  one-clock pulse on frame timing error

Behaviour:
- Reset (reset==0 at posedge CLOCK_50):
  - hcnt = vcnt = 0, hs_q = vs_q = 1, state = SEARCH.
  - Outputs: x = y = 1023; active, rgb_out, frame_start, locked, err_* all 0.
  - Applies mid-frame with no exceptions.
- Sampling:
  - All state advances only on cycles with pix_en = 1; when pix_en = 0 everything holds, and pulse outputs are 0 on those cycles.
  - Outputs are registered: latency is 1 CLOCK_50 cycle after the sampling cycle.
- Edge detection: hs_fall = !hs & hs_q; vs_fall = !vs & vs_q.
- Horizontal counter:
  - hcnt (11b): 0 on hs_fall, else +1, saturating at 2047.
  - hs_w (8b) counts samples with hs = 0 since hs_fall, saturating.
- Line check at each hs_fall:
  - line_bad if hcnt+1 != H_TOTAL, or the previous hs_w != H_SYNC.
  - Any hcnt saturation is line_bad.
  - The first hs_fall after SEARCH is not checked.
- Vertical counter:
  - vcnt (11b): 0 on vs_fall (vs_fall occurs coincident with hs_fall), else +1 on hs_fall, saturating.
  - vs_w counts lines with vs = 0.
- Frame check at vs_fall: frame_bad if vcnt+1 != V_TOTAL, vs_w != V_SYNC, or any line_bad since the previous vs_fall.
- Coordinates:
  - Window: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACT, and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACT.
  - active = locked & window.
  - x = hcnt-(H_SYNC+H_BP) and y = vcnt-(V_SYNC+V_BP) when active, else 1023.
  - rgb_out = {r,g,b} when active, else 0.
- FSM:
  - SEARCH: on vs_fall → MEASURE, good = 0.
  - MEASURE, at vs_fall:
    - frame_bad: good = 0, stay in MEASURE, err_frame pulse.
    - frame good: good+1; when good reaches LOCK_FRAMES → LOCKED.
  - MEASURE, at hs_fall with line_bad: flagged only (err_line pulse); evaluated at the next vs_fall.
  - LOCKED, line_bad at hs_fall: → SEARCH, err_line pulse.
  - LOCKED, frame_bad at vs_fall: → SEARCH, err_frame pulse.
- frame_start pulses on every vs_fall after which state is LOCKED, including the locking transition.
- Simultaneous line_bad and frame_bad on the same sample: both error pulses fire and state goes to SEARCH.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* nominal constants and derived H_TOTAL/V_TOTAL/H_START/V_START;
  - the state enum {SEARCH, MEASURE, LOCKED}.
- Sub-module sync_axis_meter, instantiated twice (horizontal and vertical):
  - inputs: advance enable and sync level;
  - behaviour: counts period and low width, flags period/width mismatch against parameters, saturates.

Test Plan:
- Nominal timing, 4 frames → locked rises 1 clock after the 3rd vs_fall sample; frame_start pulses at the 3rd and 4th vs_fall; err_* never assert.
- Locked, sample at hcnt=144, vcnt=35 → x=0, y=0, active=1, rgb_out equals input; hcnt=783 → x=639; hcnt=784 → x=1023, active=0.
- Locked, one line lengthened to 801 samples → err_line pulse at its closing hs_fall, locked=0 next cycle; relock only after 2 further good full frames.
- hsync width 95 on one line while in MEASURE → err_line pulse, err_frame at the next vs_fall, good reset to 0.
- Hold pix_en=0 for 10 clocks mid-line while locked → x, y, rgb_out frozen, no pulses.
- reset=0 for one cycle mid-frame while locked → next cycle all outputs at reset values and state SEARCH.
